// File: rtl/countdown_pkg.sv
// Shared types and constants for the BCD countdown timer.
// Latency: n/a (declarations only).
// Backpressure: n/a (no flow control in this block).
package countdown_pkg;

  // Timer control states, two bits wide.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  // Largest legal value of a generic BCD digit and of the seconds-tens digit.
  localparam int DIGIT_MAX    = 9;
  localparam int SEC_TENS_MAX = 5;

  // Packed {min_tens, min_ones, sec_tens, sec_ones} value of 00:01.
  localparam logic [15:0] COUNT_ONE = 16'h0001;

  // Clamp a preset digit to the largest value that digit position may hold.
  function automatic logic [3:0] bcd_sat(input logic [3:0] val, input logic [3:0] max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of a down-counter: loadable, decrements on borrow, wraps 0 -> MAX.
// Latency: digit updates on the clk edge after load/dec; borrow_out is combinational.
// Backpressure: none; load takes precedence over dec.
module bcd_down_digit
  import countdown_pkg::*;
#(
  parameter int MAX = DIGIT_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  input  logic       borrow_in,
  output logic [3:0] digit,
  output logic       borrow_out
);

  localparam logic [3:0] MAX_V = 4'(MAX);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  // Next digit value: saturating load, otherwise decrement with wrap when a borrow arrives.
  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = bcd_sat(load_val, MAX_V);
    end else if (dec && borrow_in) begin
      digit_d = (digit_q == 4'd0) ? MAX_V : (digit_q - 4'd1);
    end
  end

  // Digit register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  // A borrow passes upward only when this digit is already zero; with the
  // lowest digit's borrow_in tied high, the top borrow_out flags an all-zero count.
  assign borrow_out = borrow_in && (digit_q == 4'd0);
  assign digit      = digit_q;

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer with start/pause/clear, expiry pulse and self-clearing alarm.
// Latency: commands and ticks take effect on the next clk edge; all outputs registered.
// Backpressure: none; simultaneous commands resolve as clear > load > pause > start.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int ALARM_TICKS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  output logic [7:0] min,
  output logic [7:0] sec,
  output logic       running,
  output logic       alarm,
  output logic       done
);

  localparam logic [7:0] ALARM_LIMIT = 8'(ALARM_TICKS);

  state_e     state_q;
  logic       running_q;
  logic       alarm_q;
  logic       done_q;
  logic [7:0] alarm_cnt_q;
  logic [7:0] alarm_cnt_d;

  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       borrow_so;
  logic       borrow_st;
  logic       borrow_mo;
  logic       count_zero;
  logic [15:0] count;

  logic       digit_load;
  logic       digit_dec;
  logic [7:0] min_val;
  logic [7:0] sec_val;

  assign count = {min_tens, min_ones, sec_tens, sec_ones};

  // Presets are accepted only while stopped (IDLE or PAUSE); clear reuses the
  // load path with a zero value so the digits need no separate clear input.
  assign digit_load = clear || (load && ((state_q == ST_IDLE) || (state_q == ST_PAUSE)));
  assign min_val    = clear ? 8'h00 : load_min;
  assign sec_val    = clear ? 8'h00 : load_sec;

  // A tick counts down only in RUN and only when no pause or clear wins the cycle.
  assign digit_dec  = !clear && (state_q == ST_RUN) && tick && !pause;

  assign alarm_cnt_d = alarm_cnt_q + 8'd1;

  bcd_down_digit #(.MAX(DIGIT_MAX)) u_sec_ones (
    .clk        (clk),
    .rst        (reset),
    .load       (digit_load),
    .load_val   (sec_val[3:0]),
    .dec        (digit_dec),
    .borrow_in  (1'b1),
    .digit      (sec_ones),
    .borrow_out (borrow_so)
  );

  bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk        (clk),
    .rst        (reset),
    .load       (digit_load),
    .load_val   (sec_val[7:4]),
    .dec        (digit_dec),
    .borrow_in  (borrow_so),
    .digit      (sec_tens),
    .borrow_out (borrow_st)
  );

  bcd_down_digit #(.MAX(DIGIT_MAX)) u_min_ones (
    .clk        (clk),
    .rst        (reset),
    .load       (digit_load),
    .load_val   (min_val[3:0]),
    .dec        (digit_dec),
    .borrow_in  (borrow_st),
    .digit      (min_ones),
    .borrow_out (borrow_mo)
  );

  bcd_down_digit #(.MAX(DIGIT_MAX)) u_min_tens (
    .clk        (clk),
    .rst        (reset),
    .load       (digit_load),
    .load_val   (min_val[7:4]),
    .dec        (digit_dec),
    .borrow_in  (borrow_mo),
    .digit      (min_tens),
    .borrow_out (count_zero)
  );

  // Control FSM with registered status outputs and the alarm tick counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      running_q   <= 1'b0;
      alarm_q     <= 1'b0;
      done_q      <= 1'b0;
      alarm_cnt_q <= 8'd0;
    end else begin
      done_q <= 1'b0;
      if (clear) begin
        state_q     <= ST_IDLE;
        running_q   <= 1'b0;
        alarm_q     <= 1'b0;
        alarm_cnt_q <= 8'd0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            // load and pause both outrank start; a zero count cannot be started.
            if (!load && !pause && start && !count_zero) begin
              state_q   <= ST_RUN;
              running_q <= 1'b1;
            end
          end
          ST_RUN: begin
            if (pause) begin
              state_q   <= ST_PAUSE;
              running_q <= 1'b0;
            end else if (tick && (count == COUNT_ONE)) begin
              state_q     <= ST_EXPIRED;
              running_q   <= 1'b0;
              alarm_q     <= 1'b1;
              done_q      <= 1'b1;
              alarm_cnt_q <= 8'd0;
            end
          end
          ST_PAUSE: begin
            if (load) begin
              state_q <= ST_IDLE;
            end else if (!pause && start) begin
              state_q   <= ST_RUN;
              running_q <= 1'b1;
            end
          end
          ST_EXPIRED: begin
            if (tick) begin
              if (alarm_cnt_d == ALARM_LIMIT) begin
                state_q     <= ST_IDLE;
                alarm_q     <= 1'b0;
                alarm_cnt_q <= 8'd0;
              end else begin
                alarm_cnt_q <= alarm_cnt_d;
              end
            end
          end
          default: begin
            state_q     <= ST_IDLE;
            running_q   <= 1'b0;
            alarm_q     <= 1'b0;
            alarm_cnt_q <= 8'd0;
          end
        endcase
      end
    end
  end

  assign min     = {min_tens, min_ones};
  assign sec     = {sec_tens, sec_ones};
  assign running = running_q;
  assign alarm   = alarm_q;
  assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with a three-tick alarm timeout.
// Latency: checks sample 1 time unit after each rising clk edge.
// Backpressure: n/a.
module tb_countdown_timer;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       load;
  logic [7:0] load_min;
  logic [7:0] load_sec;
  logic       start;
  logic       pause;
  logic       clear;
  logic [7:0] min;
  logic [7:0] sec;
  logic       running;
  logic       alarm;
  logic       done;

  int chk_total;
  int chk_pass;

  countdown_timer #(.ALARM_TICKS(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .load     (load),
    .load_min (load_min),
    .load_sec (load_sec),
    .start    (start),
    .pause    (pause),
    .clear    (clear),
    .min      (min),
    .sec      (sec),
    .running  (running),
    .alarm    (alarm),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_inputs();
    tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] m, input logic [7:0] s);
    load_min = m; load_sec = s; load = 1'b1; step(); load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1; step(); tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drop_inputs();
    load_min = 8'h00; load_sec = 8'h00;
    step(); step();
    chk_total++;
    if ({min, sec, running, alarm, done} !== 19'h0)
      $display("FAIL reset_outputs got min=%h sec=%h run=%b alarm=%b done=%b exp all zero", min, sec, running, alarm, done);
    else chk_pass++;
    // First command after release lands on the first edge with reset low.
    reset = 1'b0;
    do_load(8'h12, 8'h34);
    chk_total++;
    if ({min, sec} !== 16'h1234) $display("FAIL reset_first_load got %h exp 1234", {min, sec});
    else chk_pass++;
  endtask

  task automatic test_basic();
    do_clear();
    do_load(8'h00, 8'h03);
    do_start();
    chk_total++;
    if (running !== 1'b1) $display("FAIL basic_running got %b exp 1", running);
    else chk_pass++;
    do_tick();
    chk_total++;
    if ({sec, done} !== 9'h04) $display("FAIL basic_sec2 got sec=%h done=%b exp sec=02 done=0", sec, done);
    else chk_pass++;
    do_tick();
    chk_total++;
    if (sec !== 8'h01) $display("FAIL basic_sec1 got %h exp 01", sec);
    else chk_pass++;
    do_tick();
    chk_total++;
    if ({min, sec, done, alarm, running} !== 19'b0000_0000_0000_0000_110)
      $display("FAIL basic_expire got min=%h sec=%h done=%b alarm=%b run=%b exp 00:00 1 1 0", min, sec, done, alarm, running);
    else chk_pass++;
    step();
    chk_total++;
    if ({done, alarm, sec} !== 10'b01_0000_0000) $display("FAIL basic_done_pulse got done=%b alarm=%b sec=%h exp 0 1 00", done, alarm, sec);
    else chk_pass++;
  endtask

  // Continues from EXPIRED left by test_basic.
  task automatic test_alarm_timeout();
    do_tick();
    chk_total++;
    if (alarm !== 1'b1) $display("FAIL alarm_tick1 got %b exp 1", alarm);
    else chk_pass++;
    // start/pause/load are ignored while the alarm sounds.
    start = 1'b1; pause = 1'b1; load = 1'b1; load_min = 8'h01; load_sec = 8'h11;
    step();
    drop_inputs();
    chk_total++;
    if ({alarm, min, sec} !== 17'h10000) $display("FAIL alarm_ignore_cmds got alarm=%b %h:%h exp 1 00:00", alarm, min, sec);
    else chk_pass++;
    do_tick();
    chk_total++;
    if (alarm !== 1'b1) $display("FAIL alarm_tick2 got %b exp 1", alarm);
    else chk_pass++;
    do_tick();
    chk_total++;
    if ({alarm, running} !== 2'b00) $display("FAIL alarm_tick3 got alarm=%b run=%b exp 0 0", alarm, running);
    else chk_pass++;
    // Now in IDLE, so a load is accepted.
    do_load(8'h00, 8'h05);
    chk_total++;
    if (sec !== 8'h05) $display("FAIL alarm_back_idle got %h exp 05", sec);
    else chk_pass++;
  endtask

  task automatic test_borrow();
    do_clear();
    do_load(8'h10, 8'h00);
    do_start();
    do_tick();
    chk_total++;
    if ({min, sec} !== 16'h0959) $display("FAIL borrow_10_00 got %h exp 0959", {min, sec});
    else chk_pass++;
    do_clear();
    do_load(8'h00, 8'h10);
    do_start();
    do_tick();
    chk_total++;
    if ({min, sec} !== 16'h0009) $display("FAIL borrow_00_10 got %h exp 0009", {min, sec});
    else chk_pass++;
    do_clear();
    do_load(8'h99, 8'h59);
    do_start();
    do_tick();
    chk_total++;
    if ({min, sec} !== 16'h9958) $display("FAIL borrow_max got %h exp 9958", {min, sec});
    else chk_pass++;
  endtask

  task automatic test_pause();
    do_clear();
    do_load(8'h05, 8'h31);
    do_start();
    do_tick();
    chk_total++;
    if ({min, sec} !== 16'h0530) $display("FAIL pause_pre got %h exp 0530", {min, sec});
    else chk_pass++;
    pause = 1'b1; tick = 1'b1; step(); pause = 1'b0; tick = 1'b0;
    chk_total++;
    if ({min, sec, running} !== 17'h0a60) $display("FAIL pause_tick got %h run=%b exp 0530 0", {min, sec}, running);
    else chk_pass++;
    do_tick();
    chk_total++;
    if ({min, sec} !== 16'h0530) $display("FAIL pause_hold got %h exp 0530", {min, sec});
    else chk_pass++;
    do_start();
    chk_total++;
    if (running !== 1'b1) $display("FAIL pause_resume got %b exp 1", running);
    else chk_pass++;
    do_tick();
    chk_total++;
    if ({min, sec} !== 16'h0529) $display("FAIL pause_after got %h exp 0529", {min, sec});
    else chk_pass++;
  endtask

  task automatic test_clear_expired();
    do_clear();
    do_load(8'h00, 8'h01);
    do_start();
    do_tick();
    do_tick();
    do_tick();
    do_clear();
    chk_total++;
    if ({alarm, min, sec} !== 17'h0) $display("FAIL clear_expired got alarm=%b %h:%h exp 0 00:00", alarm, min, sec);
    else chk_pass++;
    // Two alarm ticks before clear must not carry into the next alarm.
    do_load(8'h00, 8'h01);
    do_start();
    do_tick();
    do_tick();
    do_tick();
    chk_total++;
    if (alarm !== 1'b1) $display("FAIL clear_alarm_cnt got %b exp 1", alarm);
    else chk_pass++;
    do_clear();
  endtask

  task automatic test_saturate();
    do_clear();
    do_load(8'h7A, 8'h9F);
    chk_total++;
    if ({min, sec} !== 16'h7959) $display("FAIL sat_load got %h exp 7959", {min, sec});
    else chk_pass++;
    do_clear();
    load_min = 8'h00; load_sec = 8'h07; load = 1'b1; start = 1'b1;
    step();
    drop_inputs();
    chk_total++;
    if ({sec, running} !== 9'h00e) $display("FAIL load_start got sec=%h run=%b exp 07 0", sec, running);
    else chk_pass++;
    do_tick();
    chk_total++;
    if ({sec, running} !== 9'h00e) $display("FAIL load_start_idle got sec=%h run=%b exp 07 0", sec, running);
    else chk_pass++;
    // clear outranks start in the same cycle.
    clear = 1'b1; start = 1'b1; step(); drop_inputs();
    chk_total++;
    if ({sec, running} !== 9'h000) $display("FAIL clear_start got sec=%h run=%b exp 00 0", sec, running);
    else chk_pass++;
  endtask

  task automatic test_async_reset();
    do_clear();
    do_load(8'h42, 8'h18);
    do_start();
    do_tick();
    chk_total++;
    if ({min, sec, running} !== {16'h4217, 1'b1}) $display("FAIL rst_pre got %h run=%b exp 4217 1", {min, sec}, running);
    else chk_pass++;
    #2 reset = 1'b1;
    #1;
    chk_total++;
    if ({min, sec, running, alarm, done} !== 19'h0) $display("FAIL rst_async got %h run=%b exp 0000 0", {min, sec}, running);
    else chk_pass++;
    step();
    reset = 1'b0;
    do_start();
    chk_total++;
    if (running !== 1'b0) $display("FAIL rst_start_zero got %b exp 0", running);
    else chk_pass++;
  endtask

  initial begin
    chk_total = 0;
    chk_pass  = 0;
    test_reset();
    test_basic();
    test_alarm_timeout();
    test_borrow();
    test_pause();
    test_clear_expired();
    test_saturate();
    test_async_reset();
    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter ALARM_TICKS, default 10: number of tick pulses the alarm stays asserted in EXPIRED before it auto-clears; legal range 1..255.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 tick  input  1  one-cycle enable, once per second (from the upCounter prescaler chain).
REQ-005 load  input  1  load the preset from load_min/load_sec.
REQ-006 load_min  input  8  BCD minutes preset, tens in [7:4], ones in [3:0].
REQ-007 load_sec  input  8  BCD seconds preset, tens in [7:4], ones in [3:0].
REQ-008 start  input  1  begin or resume the countdown.
REQ-009 pause  input  1  freeze the countdown.
REQ-010 clear  input  1  abort or acknowledge; return to idle with zero count.
REQ-011 min  output  8  current BCD minutes, registered.
REQ-012 sec  output  8  current BCD seconds, registered.
REQ-013 running  output  1  high while state is RUN.
REQ-014 alarm  output  1  high while state is EXPIRED.
REQ-015 done  output  1  one-cycle pulse on entry to EXPIRED.

Function
REQ-016 The block SHALL implement states IDLE, RUN, PAUSE and EXPIRED; all outputs are registered.
REQ-017 Command priority SHALL be clear > load > pause > start whenever more than one is asserted in the same cycle.
REQ-018 clear in any state SHALL force IDLE, min=sec=0x00, alarm=0 and the alarm tick count to 0 on the next edge.
REQ-019 In IDLE, load SHALL capture the preset; in PAUSE, load SHALL capture the preset and go to IDLE; in RUN and EXPIRED, load SHALL be ignored.
REQ-020 A loaded BCD digit greater than 9 SHALL saturate to 9, and a seconds-tens digit greater than 5 SHALL saturate to 5.
REQ-021 In IDLE, start SHALL enter RUN only if the count is nonzero; otherwise the block stays in IDLE.
REQ-022 In RUN, pause SHALL enter PAUSE; a tick in the same cycle as pause SHALL be ignored.
REQ-023 In PAUSE, ticks SHALL be ignored and start SHALL return to RUN.
REQ-024 In RUN, each tick SHALL decrement the count by one second, visible on min/sec one cycle after the tick edge.
REQ-025 Decrement SHALL use a BCD borrow chain:
- seconds ones 0->9 with borrow
- seconds tens 0->5 with borrow
- minutes ones 0->9 with borrow
- minutes tens 0->9
- maximum count is 99:59
REQ-026 A tick in RUN with count 00:01 SHALL set the count to 00:00, enter EXPIRED and assert done for exactly one cycle, all coincident on the same edge.
REQ-027 In EXPIRED, the count SHALL hold 00:00 and alarm SHALL be 1.
REQ-028 In EXPIRED, each tick SHALL increment an 8-bit alarm tick counter; on the ALARM_TICKS-th tick the block SHALL go to IDLE with alarm=0.
REQ-029 start and pause SHALL have no effect in EXPIRED.
REQ-030 running SHALL equal (state==RUN), and alarm SHALL equal (state==EXPIRED).

Reset
REQ-031 Asserting reset at any time, including mid-countdown, SHALL immediately force IDLE, min=0x00, sec=0x00, running=0, alarm=0, done=0 and the alarm tick counter to 0.
REQ-032 The first command after reset release SHALL be honored on the first rising clk edge where reset is low.

Structure
REQ-033 A shared package countdown_pkg SHALL hold:
- the state enumeration (2-bit)
- BCD constants DIGIT_MAX=9 and SEC_TENS_MAX=5
REQ-034 The block SHALL instantiate four copies of sub-module bcd_down_digit, each with:
- parameter MAX
- inputs load, load_val, dec, borrow_in
- outputs digit, borrow_out
Digits SHALL be chained seconds ones -> seconds tens -> minutes ones -> minutes tens.
REQ-035 The FSM and the alarm tick counter SHALL reside in countdown_timer.

Verification
REQ-036 Load 00:03, start, apply 3 ticks -> sec = 0x02, 0x01, 0x00; done pulses one cycle with the third update; alarm=1; running=0.
REQ-037 Load 10:00, start, apply 1 tick -> min=0x09, sec=0x59.
REQ-038 In RUN at 05:30, assert pause and tick together -> count stays 05:30, state PAUSE; then start plus 1 tick -> 05:29.
REQ-039 With ALARM_TICKS=3, reach EXPIRED, apply 3 ticks -> alarm falls on the edge of the third tick and the block is in IDLE; a separate run with clear asserted in EXPIRED -> alarm=0 on the next edge.
REQ-040 Load with load_min=0x7A, load_sec=0x9F -> min=0x79, sec=0x59; load plus start in the same cycle from IDLE -> preset captured, remains in IDLE.
REQ-041 Assert reset asynchronously mid-RUN at 42:17 -> outputs 00:00 with running=0 before the next clk edge; start with zero count -> stays IDLE.
